// File: rtl/axis_spi_arbiter.sv
// axis_spi_arbiter: round-robin sharing of one axis_spi_master
// between NUM_REQ packet requesters, with in-order RX return.
module axis_spi_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int DATA_WIDTH      = 8,
    parameter int SLAVE_NUM       = 1,
    parameter int MAX_OUTSTANDING = 4,
    localparam int ADDR_W = (SLAVE_NUM > 1) ? $clog2(SLAVE_NUM) : 1
) (
    input  logic                          clk_i,
    input  logic                          arstn_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_tdata_i,
    input  logic [NUM_REQ-1:0]            req_tvalid_i,
    input  logic [NUM_REQ-1:0]            req_tlast_i,
    output logic [NUM_REQ-1:0]            req_tready_o,
    input  logic [NUM_REQ*ADDR_W-1:0]     req_addr_i,
    output logic [NUM_REQ*DATA_WIDTH-1:0] rsp_tdata_o,
    output logic [NUM_REQ-1:0]            rsp_tvalid_o,
    output logic                          rsp_tlast_o,
    input  logic [NUM_REQ-1:0]            rsp_tready_i,
    output logic [DATA_WIDTH-1:0]         spi_tdata_o,
    output logic                          spi_tvalid_o,
    input  logic                          spi_tready_i,
    input  logic [DATA_WIDTH-1:0]         spi_rx_tdata_i,
    input  logic                          spi_rx_tvalid_i,
    output logic                          spi_rx_tready_o,
    output logic [ADDR_W-1:0]             spi_addr_o,
    output logic [NUM_REQ-1:0]            grant_o,
    output logic                          busy_o,
    output logic                          drop_o
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        ARB,
        XFER,
        DRAIN
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   gidx_q, gidx_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [CNT_W-1:0]   outst_q, outst_d;

    logic             found;
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] cand;

    logic g_valid;
    logic g_last;
    logic g_rready;
    logic room;
    logic rx_path;
    logic tx_hs;
    logic rx_hs;

    // first valid requester after the last one served, wrapping
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'((int'(last_q) + i) % NUM_REQ);
            if (!found && req_tvalid_i[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    assign g_valid  = req_tvalid_i[gidx_q];
    assign g_last   = req_tlast_i[gidx_q];
    assign g_rready = rsp_tready_i[gidx_q];
    assign room     = outst_q < CNT_MAX;
    assign rx_path  = (state_q == XFER) || (state_q == DRAIN);

    assign tx_hs = (state_q == XFER) && g_valid
                   && room && spi_tready_i;
    assign rx_hs = rx_path && spi_rx_tvalid_i && g_rready;

    always_comb begin
        spi_tvalid_o    = 1'b0;
        req_tready_o    = '0;
        rsp_tvalid_o    = '0;
        spi_rx_tready_o = 1'b0;
        if (state_q == XFER) begin
            spi_tvalid_o         = g_valid && room;
            req_tready_o[gidx_q] = spi_tready_i && room;
        end
        if (rx_path) begin
            rsp_tvalid_o[gidx_q] = spi_rx_tvalid_i;
            spi_rx_tready_o      = g_rready;
        end else if (state_q == IDLE) begin
            spi_rx_tready_o = 1'b1;
        end
    end

    assign spi_tdata_o = req_tdata_i[gidx_q*DATA_WIDTH +: DATA_WIDTH];
    assign rsp_tdata_o = {NUM_REQ{spi_rx_tdata_i}};
    assign rsp_tlast_o = (state_q == DRAIN) && (outst_q == CNT_ONE);
    assign drop_o      = (state_q == IDLE) && spi_rx_tvalid_i;
    assign busy_o      = state_q != IDLE;
    assign grant_o     = grant_q;
    assign spi_addr_o  = addr_q;

    // an RX with nothing outstanding is passed on but never underflows
    always_comb begin
        outst_d = outst_q;
        if (tx_hs && !rx_hs) begin
            outst_d = outst_q + CNT_ONE;
        end else if (rx_hs && !tx_hs && outst_q != '0) begin
            outst_d = outst_q - CNT_ONE;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        last_d  = last_q;
        addr_d  = addr_q;
        unique case (state_q)
            IDLE: begin
                if (|req_tvalid_i) begin
                    state_d = ARB;
                end
            end
            ARB: begin
                if (found) begin
                    state_d       = XFER;
                    gidx_d        = pick;
                    grant_d       = '0;
                    grant_d[pick] = 1'b1;
                    addr_d = req_addr_i[pick*ADDR_W +: ADDR_W];
                end else begin
                    state_d = IDLE;
                end
            end
            XFER: begin
                if (tx_hs && g_last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (outst_q == '0 || (rx_hs && outst_q == CNT_ONE)) begin
                    state_d = IDLE;
                    last_d  = gidx_q;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!arstn_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
            addr_q  <= '0;
            outst_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            outst_q <= outst_d;
        end
    end

endmodule

// File: tb/tb_axis_spi_arbiter.sv
// Bench for axis_spi_arbiter: random requesters and SPI master model,
// scoreboard of expected RX bytes and a round-robin grant model.
module tb_axis_spi_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int SN = 4;
    localparam int MO = 2;
    localparam int AW = 2;

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
        logic [AW-1:0] a;
    } tx_t;

    typedef struct {
        int            k;
        logic [DW-1:0] d;
        logic          l;
    } exp_t;

    typedef struct {
        logic [DW-1:0] d;
        int            t;
    } mst_t;

    logic               clk = 1'b0;
    logic               arstn_i;
    logic [NR*DW-1:0]   req_tdata_i;
    logic [NR-1:0]      req_tvalid_i;
    logic [NR-1:0]      req_tlast_i;
    logic [NR-1:0]      req_tready_o;
    logic [NR*AW-1:0]   req_addr_i;
    logic [NR*DW-1:0]   rsp_tdata_o;
    logic [NR-1:0]      rsp_tvalid_o;
    logic               rsp_tlast_o;
    logic [NR-1:0]      rsp_tready_i;
    logic [DW-1:0]      spi_tdata_o;
    logic               spi_tvalid_o;
    logic               spi_tready_i;
    logic [DW-1:0]      spi_rx_tdata_i;
    logic               spi_rx_tvalid_i;
    logic               spi_rx_tready_o;
    logic [AW-1:0]      spi_addr_o;
    logic [NR-1:0]      grant_o;
    logic               busy_o;
    logic               drop_o;

    always #5 clk = ~clk;

    axis_spi_arbiter #(
        .NUM_REQ(NR),
        .DATA_WIDTH(DW),
        .SLAVE_NUM(SN),
        .MAX_OUTSTANDING(MO)
    ) dut (
        .clk_i(clk),
        .arstn_i(arstn_i),
        .req_tdata_i(req_tdata_i),
        .req_tvalid_i(req_tvalid_i),
        .req_tlast_i(req_tlast_i),
        .req_tready_o(req_tready_o),
        .req_addr_i(req_addr_i),
        .rsp_tdata_o(rsp_tdata_o),
        .rsp_tvalid_o(rsp_tvalid_o),
        .rsp_tlast_o(rsp_tlast_o),
        .rsp_tready_i(rsp_tready_i),
        .spi_tdata_o(spi_tdata_o),
        .spi_tvalid_o(spi_tvalid_o),
        .spi_tready_i(spi_tready_i),
        .spi_rx_tdata_i(spi_rx_tdata_i),
        .spi_rx_tvalid_i(spi_rx_tvalid_i),
        .spi_rx_tready_o(spi_rx_tready_o),
        .spi_addr_o(spi_addr_o),
        .grant_o(grant_o),
        .busy_o(busy_o),
        .drop_o(drop_o)
    );

    int   checks = 0;
    int   failures = 0;
    tx_t  txq[NR][$];
    exp_t sb[$];
    mst_t mq[$];
    int   glog[$];
    bit   started[NR];
    int   cyc = 0;
    int   tx_count = 0;
    int   valid_pct = 100;
    int   spi_pct = 100;
    int   rsp_pct = 100;
    int   max_dly = 0;
    bit   sb_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // slave model: each address returns the MOSI byte xor a fixed mask
    function automatic logic [DW-1:0] scr(input logic [AW-1:0] a);
        return {4{a}};
    endfunction

    task automatic load(input int k, input int n, input logic [AW-1:0] a);
        tx_t e;
        for (int i = 0; i < n; i++) begin
            e.d = DW'($urandom);
            e.l = (i == n - 1);
            e.a = a;
            txq[k].push_back(e);
        end
    endtask

    task automatic step();
        bit [NR-1:0] hs;
        tx_t  e;
        exp_t x;
        mst_t m;
        @(negedge clk);
        hs = '0;
        for (int k = 0; k < NR; k++) begin
            if (req_tvalid_i[k] && req_tready_o[k] && txq[k].size() > 0) begin
                hs[k] = 1'b1;
                e = txq[k].pop_front();
                x.k = k;
                x.d = e.d ^ scr(e.a);
                x.l = e.l;
                sb.push_back(x);
                started[k] = !e.l;
                tx_count++;
            end
        end
        if (spi_tvalid_o && spi_tready_i) begin
            m.d = spi_tdata_o ^ scr(spi_addr_o);
            m.t = cyc + $urandom_range(max_dly);
            mq.push_back(m);
        end
        if (spi_rx_tvalid_i && spi_rx_tready_o && mq.size() > 0) begin
            void'(mq.pop_front());
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < NR; k++) begin
            bit keep;
            keep = req_tvalid_i[k] && !hs[k];
            if (txq[k].size() > 0) begin
                req_tvalid_i[k] = keep || ($urandom_range(99) < valid_pct);
                req_tdata_i[k*DW +: DW] = txq[k][0].d;
                req_tlast_i[k] = txq[k][0].l;
                req_addr_i[k*AW +: AW] =
                    started[k] ? ~txq[k][0].a : txq[k][0].a;
            end else begin
                req_tvalid_i[k] = 1'b0;
                req_tlast_i[k] = 1'b0;
                req_tdata_i[k*DW +: DW] = DW'($urandom);
                req_addr_i[k*AW +: AW] = AW'($urandom);
            end
            rsp_tready_i[k] = $urandom_range(99) < rsp_pct;
        end
        spi_tready_i = $urandom_range(99) < spi_pct;
        if (mq.size() > 0 && mq[0].t <= cyc) begin
            spi_rx_tvalid_i = 1'b1;
            spi_rx_tdata_i = mq[0].d;
        end else begin
            spi_rx_tvalid_i = 1'b0;
        end
    endtask

    function automatic bit quiet();
        bit q;
        q = (mq.size() == 0) && (sb.size() == 0) && !busy_o;
        for (int k = 0; k < NR; k++) begin
            if (txq[k].size() != 0) q = 1'b0;
        end
        return q;
    endfunction

    task automatic run_idle(input int maxc, input string nm);
        int c;
        c = 0;
        while (c < maxc && !quiet()) begin
            step();
            c++;
        end
        chk(nm, (c < maxc) ? 1 : 0, 1);
    endtask

    // monitor: grant model, address hold, throttle and RX scoreboard
    int              exp_last = NR - 1;
    int              infl = 0;
    int              ek;
    int              n_rsp;
    int              kk;
    logic [NR-1:0]   prev_grant = '0;
    logic [NR-1:0]   prev_valid = '0;
    logic [NR*AW-1:0] prev_addr = '0;
    logic [AW-1:0]   exp_addr = '0;
    logic [NR-1:0]   egrant;
    logic            m_tx;
    logic            m_rx;
    exp_t            me;

    always @(negedge clk) begin
        if (!arstn_i) begin
            exp_last = NR - 1;
            infl = 0;
            prev_grant = '0;
        end else if (sb_en) begin
            chk("grant_onehot", $onehot0(grant_o) ? 1 : 0, 1);
            if (prev_grant == '0 && grant_o != '0) begin
                ek = -1;
                for (int i = 1; i <= NR; i++) begin
                    if (ek < 0 && prev_valid[(exp_last + i) % NR]) begin
                        ek = (exp_last + i) % NR;
                    end
                end
                egrant = '0;
                if (ek >= 0) egrant[ek] = 1'b1;
                chk("grant", grant_o, egrant);
                if (ek >= 0) begin
                    exp_last = ek;
                    exp_addr = prev_addr[ek*AW +: AW];
                    glog.push_back(ek);
                end
            end
            if (grant_o != '0) begin
                chk("spi_addr", spi_addr_o, exp_addr);
                chk("busy", busy_o, 1);
            end
            if (spi_tvalid_o) begin
                chk("throttle", (infl < MO) ? 1 : 0, 1);
            end
            m_tx = spi_tvalid_o && spi_tready_i;
            m_rx = spi_rx_tvalid_i && spi_rx_tready_o && busy_o;
            n_rsp = 0;
            kk = 0;
            for (int k = 0; k < NR; k++) begin
                if (rsp_tvalid_o[k] && rsp_tready_i[k]) begin
                    n_rsp++;
                    kk = k;
                end
            end
            if (m_rx || n_rsp != 0) begin
                chk("rx_route", n_rsp, m_rx ? 1 : 0);
                if (n_rsp == 1) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL sb_empty: got byte %0h for req %0d expected none",
                                 rsp_tdata_o[kk*DW +: DW], kk);
                    end else begin
                        me = sb.pop_front();
                        chk("rsp_req", kk, me.k);
                        chk("rsp_data", rsp_tdata_o[kk*DW +: DW], me.d);
                        chk("rsp_last", rsp_tlast_o, me.l);
                    end
                end
            end
            infl = infl + (m_tx ? 1 : 0) - (m_rx ? 1 : 0);
            prev_grant = grant_o;
        end
        prev_valid = req_tvalid_i;
        prev_addr = req_addr_i;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    int rr_exp[6] = '{0, 2, 3, 0, 2, 3};
    int t0;
    int c;
    tx_t e0;

    initial begin
        arstn_i = 1'b0;
        req_tdata_i = '0;
        req_tvalid_i = '1;
        req_tlast_i = '0;
        req_addr_i = '0;
        rsp_tready_i = '1;
        spi_tready_i = 1'b1;
        spi_rx_tdata_i = '0;
        spi_rx_tvalid_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_grant", grant_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_addr", spi_addr_o, 0);
        chk("rst_drop", drop_o, 0);
        chk("rst_req_tready", req_tready_o, 0);
        chk("rst_rsp_tvalid", rsp_tvalid_o, 0);
        chk("rst_rsp_tlast", rsp_tlast_o, 0);
        chk("rst_spi_tvalid", spi_tvalid_o, 0);
        chk("rst_rx_tready", spi_rx_tready_o, 1);
        @(posedge clk);
        #1;
        req_tvalid_i = '0;
        arstn_i = 1'b1;
        sb_en = 1'b1;

        // round robin among 0, 2, 3 with back-to-back 2-byte packets
        spi_pct = 80;
        rsp_pct = 80;
        max_dly = 2;
        for (int r = 0; r < 2; r++) begin
            load(0, 2, 2'd1);
            load(2, 2, 2'd2);
            load(3, 2, 2'd3);
        end
        glog.delete();
        run_idle(500, "rr_done");
        chk("rr_len", glog.size(), 6);
        for (int i = 0; i < 6 && i < glog.size(); i++) begin
            chk("rr_order", glog[i], rr_exp[i]);
        end

        // single requester, fixed bytes, address 0 loops back unchanged
        e0.a = 2'd0;
        e0.l = 1'b0;
        e0.d = 8'hA5;
        txq[0].push_back(e0);
        e0.d = 8'h3C;
        txq[0].push_back(e0);
        e0.d = 8'h81;
        e0.l = 1'b1;
        txq[0].push_back(e0);
        run_idle(200, "single_done");
        chk("single_grant_clr", grant_o, 0);

        // outstanding limit with RX stalled; address changes mid-packet
        spi_pct = 100;
        rsp_pct = 0;
        max_dly = 0;
        load(1, 4, 2'd2);
        t0 = tx_count;
        repeat (12) step();
        chk("throttle_cnt", tx_count - t0, MO);
        chk("throttle_tvalid", spi_tvalid_o, 0);
        chk("addr_hold", spi_addr_o, 2);
        rsp_pct = 100;
        run_idle(200, "throttle_done");

        // random traffic
        valid_pct = 60;
        spi_pct = 70;
        rsp_pct = 60;
        max_dly = 4;
        for (int p = 0; p < 40; p++) begin
            load($urandom_range(NR - 1), $urandom_range(5, 1),
                 AW'($urandom));
        end
        run_idle(8000, "random_done");

        // reset in the middle of a packet
        valid_pct = 100;
        spi_pct = 100;
        rsp_pct = 0;
        max_dly = 0;
        load(0, 3, 2'd1);
        t0 = tx_count;
        c = 0;
        while (tx_count == t0 && c < 50) begin
            step();
            c++;
        end
        chk("rst_mid_first_tx", tx_count - t0, 1);
        arstn_i = 1'b0;
        sb_en = 1'b0;
        req_tvalid_i = '0;
        spi_tready_i = 1'b0;
        spi_rx_tvalid_i = 1'b0;
        @(posedge clk);
        #1;
        arstn_i = 1'b1;
        sb.delete();
        for (int k = 0; k < NR; k++) begin
            txq[k].delete();
            started[k] = 1'b0;
        end
        chk("rst_mid_grant", grant_o, 0);
        chk("rst_mid_busy", busy_o, 0);
        chk("rst_mid_tvalid", spi_tvalid_o, 0);
        chk("rst_mid_tlast", rsp_tlast_o, 0);
        chk("rst_mid_rx_tready", spi_rx_tready_o, 1);
        spi_rx_tvalid_i = 1'b1;
        spi_rx_tdata_i = (mq.size() > 0) ? mq[0].d : 8'h5A;
        @(negedge clk);
        chk("late_drop", drop_o, 1);
        @(posedge clk);
        #1;
        spi_rx_tvalid_i = 1'b0;
        mq.delete();
        @(negedge clk);
        chk("late_drop_clr", drop_o, 0);
        @(posedge clk);
        #1;
        sb_en = 1'b1;

        // after reset the pointer restarts and the counter is clear
        rsp_pct = 100;
        glog.delete();
        load(2, 1, 2'd3);
        load(1, 2, 2'd0);
        run_idle(200, "post_rst_done");
        chk("post_rst_len", glog.size(), 2);
        if (glog.size() > 0) chk("post_rst_first", glog[0], 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axis_spi_arbiter.md
# axis_spi_arbiter

Round-robin arbiter that shares one `axis_spi_master` between `NUM_REQ` AXI-Stream requesters. Each requester presents a tlast-delimited packet plus a target slave address. The arbiter grants one requester for a whole packet, drives the master's `addr_i`, and forwards TX bytes to the master's `s_axis`. It routes every received byte from the master's `m_axis` back to the granted requester and releases the grant only after all responses have drained. It sits between the system's SPI clients and `axis_spi_master`, in the same clock domain.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8)
- `DATA_WIDTH`, 8, byte width; matches master `DATA_WIDTH`
- `SLAVE_NUM`, 1, slave count of the master; `ADDR_W = max(1, $clog2(SLAVE_NUM))`
- `MAX_OUTSTANDING`, 4, maximum TX bytes sent whose RX byte has not yet been returned
- `clk_i` in 1: system clock
- `arstn_i` in 1: reset, synchronous, active-low
- `req_tdata_i` in `NUM_REQ*DATA_WIDTH`: requester TX data; requester k occupies slice k
- `req_tvalid_i` in `NUM_REQ`: requester TX valid
- `req_tlast_i` in `NUM_REQ`: requester TX last byte of packet
- `req_tready_o` out `NUM_REQ`: requester TX ready
- `req_addr_i` in `NUM_REQ*ADDR_W`: per-requester slave select; sampled at grant
- `rsp_tdata_o` out `NUM_REQ*DATA_WIDTH`: RX data; all slices carry the same byte
- `rsp_tvalid_o` out `NUM_REQ`: RX valid, granted requester only
- `rsp_tlast_o` out 1: last RX byte of the current packet
- `rsp_tready_i` in `NUM_REQ`: requester RX ready
- `spi_tdata_o`, `spi_tvalid_o` out; `spi_tready_i` in: to master `s_axis`
- `spi_rx_tdata_i`, `spi_rx_tvalid_i` in; `spi_rx_tready_o` out: from master `m_axis`
- `spi_addr_o` out `ADDR_W`: to master `addr_i`
- `grant_o` out `NUM_REQ`: one-hot current grant, 0 when idle
- `busy_o` out 1: high in ARB, XFER and DRAIN
- `drop_o` out 1: one-cycle pulse when a stray RX byte is discarded in IDLE

## Operation
- **FSM states:** IDLE, ARB, XFER, DRAIN.
- **IDLE:**
  - If any `req_tvalid_i` is high, go to ARB.
  - `spi_rx_tready_o` = 1. Any RX byte accepted here is discarded and pulses `drop_o`.
- **ARB (1 cycle):**
  - Search requesters starting at `last_ptr+1` and wrapping modulo `NUM_REQ`.
  - Register the first requester with valid high into `grant_o`, and latch its `req_addr_i` into `spi_addr_o`. Go to XFER.
  - If no requester is valid any more, return to IDLE.
- **XFER:**
  - Forwarding: `spi_tdata_o` = granted slice; `spi_tvalid_o` = granted valid AND (`outstanding < MAX_OUTSTANDING`); granted `req_tready_o` = `spi_tready_i` under the same gate.
  - All non-granted `req_tready_o` = 0.
  - A TX handshake with tlast high moves to DRAIN. No further TX is accepted for this grant.
- **RX path (XFER and DRAIN):**
  - Granted `rsp_tvalid_o` = `spi_rx_tvalid_i`; `spi_rx_tready_o` = granted `rsp_tready_i`.
  - `rsp_tlast_o` = (state == DRAIN) AND (`outstanding == 1`).
- **`outstanding` counter** (width `$clog2(MAX_OUTSTANDING+1)`):
  - +1 on a TX handshake only.
  - -1 on an RX handshake only.
  - Unchanged when both handshakes occur in the same cycle.
  - An RX handshake while `outstanding == 0` in XFER is accepted, forwarded, and leaves the counter unchanged (no underflow).
- **DRAIN:**
  - When the RX handshake brings `outstanding` to 0, or on entry with `outstanding` already 0: set `last_ptr` = granted index, clear `grant_o`, go to IDLE.
- **`spi_addr_o` stability:** holds its value from ARB through the end of DRAIN. It changes only in ARB.
- **Reset:** `arstn_i` low at a rising edge forces IDLE, `outstanding`=0 and `last_ptr`=`NUM_REQ-1`, so requester 0 has first priority. A packet in progress is abandoned; the requester must restart it.

## Timing
- **Reset values:**
  - `grant_o`=0, `busy_o`=0, `spi_addr_o`=0, `drop_o`=0.
  - All `req_tready_o`=0, `rsp_tvalid_o`=0, `rsp_tlast_o`=0.
  - `spi_tvalid_o`=0, `spi_rx_tready_o`=1 (IDLE).
- **Arbitration latency:** valid seen in IDLE at cycle n, ARB at n+1, first TX handshake possible at n+2.
- **Back-to-back packets:** grant released in DRAIN at cycle m, IDLE at m+1, ARB at m+2.
- **TX and RX paths:** combinational pass-through, zero added latency. AXIS rule: valid never depends on ready.
- **`grant_o`, `busy_o`, `spi_addr_o`, `rsp_tlast_o`** are glitch-free with respect to the handshake. `rsp_tlast_o` depends only on registered state and `outstanding`.
- **Single-byte packet:** XFER lasts 1 handshake, then DRAIN until its RX byte returns.

## Test plan
- **Single requester:** with `req_addr`=0, requester 0 sends packet 0xA5,0x3C,0x81 (tlast on 0x81) with loopback MOSI→MISO. Required: `rsp` receives 0xA5,0x3C,0x81 with `rsp_tlast_o` only on 0x81; `grant_o` returns to 0 after the last RX byte.
- **Round-robin:** requesters 0, 2 and 3 all valid continuously with 2-byte packets. Required: grant order 0,2,3,0,2,3, and no requester is granted twice in a row while others wait.
- **Outstanding throttle:** `MAX_OUTSTANDING`=2 with the RX side stalled (`rsp_tready`=0). Required: exactly 2 TX handshakes, then `spi_tvalid_o` stays 0 until an RX handshake occurs.
- **Simultaneous TX/RX handshake:** at `outstanding`=1, TX and RX handshakes in the same cycle. Required: `outstanding` stays 1, no spurious `rsp_tlast_o`.
- **Reset mid-packet:** `arstn_i` low for 1 cycle during XFER after 1 of 3 bytes. Required: next cycle IDLE, `grant_o`=0, `outstanding`=0; a late RX byte pulses `drop_o`.
- **Address latch:** requester 1 changes `req_addr_i` mid-packet. Required: `spi_addr_o` keeps its ARB-time value until DRAIN exits.
